// File: rtl/median_arb.sv
// Round-robin arbiter sharing one fixed-latency median pipe among NREQ window sources,
// with id tagging, result FIFO and credit flow control. Define MEDIAN_ARB_STATS_EN for grant/stall counters.
module median_arb #(
  parameter int NREQ     = 2,
  parameter int W        = 8,
  parameter int PIPE_LAT = 21,
  parameter int FIDW     = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ*9*W-1:0]       req_data,
  output logic [9*W-1:0]            pipe_x,
  input  logic [W-1:0]              pipe_median,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [W-1:0]              out_data,
  output logic [$clog2(NREQ)-1:0]   out_id
`ifdef MEDIAN_ARB_STATS_EN
  ,
  output logic [NREQ*16-1:0]        stat_grants,
  output logic [15:0]               stat_stall
`endif
);

  localparam int unsigned DEPTH = 1 << FIDW;
  localparam int IDW = $clog2(NREQ);
  localparam int INW = $clog2(PIPE_LAT + 2);
  localparam int CW  = FIDW + 1;

  logic [IDW-1:0]     last, win_id, cand;
  logic               found, credit_ok, accept, tail_v, pop;
  logic [INW-1:0]     inflight;
  logic [CW-1:0]      count;
  logic [FIDW-1:0]    wr_ptr, rd_ptr;
  logic [PIPE_LAT:0]  tag_v;
  logic [IDW-1:0]     tag_id [PIPE_LAT+1];
  logic [W+IDW-1:0]   mem [DEPTH];

  // Registered occupancy only: a pop in this cycle frees credit next cycle.
  assign credit_ok = (32'(inflight) + 32'(count)) < DEPTH;

  always_comb begin
    found  = 1'b0;
    win_id = '0;
    cand   = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = IDW'((32'(last) + k) % NREQ);
      if (!found && req_valid[cand]) begin
        found  = 1'b1;
        win_id = cand;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (rst_n && found && credit_ok) req_ready[win_id] = 1'b1;
  end

  assign accept    = |req_ready;
  assign tail_v    = tag_v[PIPE_LAT];
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  assign {out_id, out_data} = out_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pipe_x   <= '0;
      last     <= IDW'(NREQ - 1);
      tag_v    <= '0;
      inflight <= '0;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      tag_v <= {tag_v[PIPE_LAT-1:0], accept};
      if (accept) begin
        pipe_x <= req_data[win_id*(9*W) +: 9*W];
        last   <= win_id;
      end
      inflight <= inflight + INW'(accept) - INW'(tail_v);
      if (tail_v) wr_ptr <= wr_ptr + FIDW'(1);
      if (pop)    rd_ptr <= rd_ptr + FIDW'(1);
      count <= count + CW'(tail_v) - CW'(pop);
    end
  end

  // Tag ids and FIFO storage carry no reset; validity lives in tag_v and count.
  always_ff @(posedge clk) begin
    tag_id[0] <= win_id;
    for (int unsigned i = 1; i <= PIPE_LAT; i++) tag_id[i] <= tag_id[i-1];
    if (rst_n && tail_v) mem[wr_ptr] <= {tag_id[PIPE_LAT], pipe_median};
  end

  assert property (@(posedge clk) disable iff (!rst_n) tail_v |-> (count < CW'(DEPTH)));

`ifdef MEDIAN_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_grants <= '0;
      stat_stall  <= '0;
    end else begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (req_ready[i] && stat_grants[i*16 +: 16] != '1)
          stat_grants[i*16 +: 16] <= stat_grants[i*16 +: 16] + 16'd1;
      end
      if ((|req_valid) && !credit_ok && stat_stall != '1)
        stat_stall <= stat_stall + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_median_arb.sv
// Scoreboard bench for median_arb with a behavioural 21-stage median pipe.
module tb_median_arb;
  localparam int NREQ = 2, W = 8, PIPE_LAT = 21, FIDW = 5, DEPTH = 32, IDW = 1;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NREQ-1:0]       req_valid, req_ready;
  logic [NREQ*9*W-1:0]   req_data;
  logic [9*W-1:0]        pipe_x;
  logic [W-1:0]          pipe_median;
  logic                  out_valid, out_ready;
  logic [W-1:0]          out_data;
  logic [IDW-1:0]        out_id;
`ifdef MEDIAN_ARB_STATS_EN
  logic [NREQ*16-1:0]    stat_grants;
  logic [15:0]           stat_stall;
`endif

  median_arb #(.NREQ(NREQ), .W(W), .PIPE_LAT(PIPE_LAT), .FIDW(FIDW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .pipe_x(pipe_x), .pipe_median(pipe_median),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_id(out_id)
`ifdef MEDIAN_ARB_STATS_EN
    , .stat_grants(stat_grants), .stat_stall(stat_stall)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] med9(input logic [9*W-1:0] x);
    logic [W-1:0] v [9];
    logic [W-1:0] t;
    for (int k = 0; k < 9; k++) v[k] = x[k*W +: W];
    for (int a = 0; a < 9; a++)
      for (int b = 0; b < 8 - a; b++)
        if (v[b] > v[b+1]) begin t = v[b]; v[b] = v[b+1]; v[b+1] = t; end
    return v[4];
  endfunction

  // Window of base+0..base+8 in scrambled order; its median is base+4.
  function automatic logic [9*W-1:0] mkwin(input int base);
    int p [9] = '{7, 2, 5, 0, 8, 3, 1, 6, 4};
    logic [9*W-1:0] w;
    for (int k = 0; k < 9; k++) w[k*W +: W] = W'(base + p[k]);
    return w;
  endfunction

  logic [W-1:0] pstage [PIPE_LAT];
  always @(posedge clk) begin
    pstage[0] <= med9(pipe_x);
    for (int i = 1; i < PIPE_LAT; i++) pstage[i] <= pstage[i-1];
  end
  assign pipe_median = pstage[PIPE_LAT-1];

  typedef struct { int id; int med; int t; bit lat; } exp_t;
  exp_t sb [$];

  int total = 0, bad = 0, cyc = 0, acc_total = 0, pop_total = 0, ov_hi = 0;
  int exp_med [NREQ];
  bit lat_chk = 1'b1;

  task automatic chk(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, want, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  // Accept observer: every handshake queues the expected result.
  always @(negedge clk) begin
    if (!rst_n) sb.delete();
    else begin
      chk("onehot_ready", int'($countones(req_ready) <= 1), 1);
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          chk("credit_bound", int'((acc_total - pop_total) < DEPTH), 1);
          sb.push_back('{i, exp_med[i], cyc + 1, lat_chk});
          acc_total++;
        end
      end
    end
  end

  exp_t e;
  logic [W-1:0]   hd;
  logic [IDW-1:0] hi;
  bit hold = 1'b0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) ov_hi++;
      if (hold && out_valid) begin
        chk("stable_data", int'(out_data), int'(hd));
        chk("stable_id", int'(out_id), int'(hi));
      end
      if (out_valid && out_ready) begin
        chk("result_pending", int'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          pop_total++;
          chk("out_data", int'(out_data), e.med);
          chk("out_id", int'(out_id), e.id);
          if (e.lat) chk("latency", cyc - e.t, PIPE_LAT + 1);
        end
      end
      hold = out_valid && !out_ready;
      hd = out_data;
      hi = out_id;
    end else hold = 1'b0;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int a0, ov0;
    int sw [9] = '{9, 1, 8, 2, 7, 3, 6, 4, 5};
    rst_n = 1'b0; req_valid = 2'b11; req_data = '0; out_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) exp_med[i] = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", int'(req_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_out_id", int'(out_id), 0);
    chk("rst_pipe_x_zero", int'(pipe_x == '0), 1);
    step(); rst_n = 1'b1; req_valid = '0;

    // Contention: alternating grants starting at requester 0.
    for (int j = 0; j < 8; j++) begin
      step();
      for (int i = 0; i < NREQ; i++) begin
        req_data[i*9*W +: 9*W] = mkwin(20 * j + 10 * i);
        exp_med[i] = 20 * j + 10 * i + 4;
      end
      req_valid = 2'b11;
      @(negedge clk);
      chk("contention_grant", int'(req_ready), (j % 2 == 0) ? 1 : 2);
    end
    step(); req_valid = '0;
    repeat (40) step();
    chk("contention_results", pop_total, 8);

    // Single window.
    a0 = acc_total; ov0 = ov_hi;
    for (int k = 0; k < 9; k++) req_data[k*W +: W] = W'(sw[k]);
    exp_med[0] = 5; req_valid = 2'b01;
    step(); req_valid = '0;
    repeat (40) step();
    chk("single_accepts", acc_total - a0, 1);
    chk("single_valid_cycles", ov_hi - ov0, 1);

    // Backpressure: credit stops at exactly DEPTH accepts.
    lat_chk = 1'b0; out_ready = 1'b0; a0 = acc_total;
    req_data[0 +: 9*W] = mkwin(60); exp_med[0] = 64; req_valid = 2'b01;
    repeat (60) step();
    chk("bp_accepts", acc_total - a0, DEPTH);
    @(negedge clk);
    chk("bp_ready_low", int'(req_ready), 0);
    step(); out_ready = 1'b1;
    step(); out_ready = 1'b0;
    repeat (30) step();
    chk("bp_one_more", acc_total - a0, DEPTH + 1);

    // Full boundary: concurrent push and pop with requests pending.
    req_data[0 +: 9*W] = mkwin(70); exp_med[0] = 74;
    out_ready = 1'b1;
    repeat (60) step();
    req_valid = '0;
    repeat (60) step();
    chk("drain_empty", sb.size(), 0);
    chk("drain_balance", acc_total - pop_total, 0);

    // Reset with windows still inside the pipe.
    lat_chk = 1'b1;
    req_data[0 +: 9*W] = mkwin(90); exp_med[0] = 94; req_valid = 2'b01;
    a0 = acc_total;
    repeat (10) step();
    req_valid = '0;
    chk("rst_inflight_accepts", acc_total - a0, 10);
    repeat (3) step();
    rst_n = 1'b0; req_valid = 2'b01;
    @(negedge clk);
    chk("midrst_req_ready", int'(req_ready), 0);
    step(); rst_n = 1'b1; req_valid = '0;
    ov0 = ov_hi;
    repeat (40) step();
    chk("midrst_no_valid", ov_hi - ov0, 0);
    req_data[0 +: 9*W] = mkwin(150); exp_med[0] = 154; req_valid = 2'b01;
    a0 = pop_total;
    step(); req_valid = '0;
    repeat (30) step();
    chk("postrst_result", pop_total - a0, 1);
    chk("postrst_empty", sb.size(), 0);

`ifdef MEDIAN_ARB_STATS_EN
    rst_n = 1'b0;
    step(); rst_n = 1'b1;
    req_data[0 +: 9*W] = mkwin(200); exp_med[0] = 204; req_valid = 2'b01;
    repeat (70000) step();
    req_valid = '0;
    repeat (30) step();
    chk("stat_grants0", int'(stat_grants[15:0]), 65535);
    chk("stat_grants1", int'(stat_grants[31:16]), 0);
    chk("stat_stall", int'(stat_stall), 0);
    chk("stats_drain", sb.size(), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/median_arb.md
# median_arb

Shares one 9-input, 8-bit median pipeline (`sort_pipe`) between `NREQ` window sources. It makes a round-robin grant each cycle and tags every accepted window with its requester ID. The tag travels alongside the fixed-latency, non-stallable pipe, and each median is collected into an output FIFO with its ID. Credit accounting ensures a result is never dropped under output backpressure.

## Interface
- `NREQ`, 2: number of requesters; 2..8.
- `W`, 8: sample width.
- `PIPE_LAT`, 21: clk edges from a `pipe_x` update to a valid `pipe_median`.
- `FIDW`, 5: log2 of the result FIFO depth (`DEPTH` = 32).
- `clk`, input, 1: single clock; all logic on the rising edge.
- `rst_n`, input, 1: synchronous, active-low reset.
- `req_valid`, input, `NREQ`: per-requester window valid.
- `req_ready`, output, `NREQ`: per-requester accept; at most one bit high.
- `req_data`, input, `NREQ*9*W`: requester i's window is slice [i*9*W +: 9*W]; sample k is at [k*W +: W].
- `pipe_x`, output, 9*W: registered window driven to the median pipe.
- `pipe_median`, input, W: median output of the pipe.
- `out_valid`, output, 1: result available.
- `out_ready`, input, 1: result consumed when it is high together with `out_valid`.
- `out_data`, output, W: median value.
- `out_id`, output, clog2(`NREQ`): requester that issued the window.
- `stat_grants`, output, `NREQ*16`: present only with `MEDIAN_ARB_STATS_EN`.
- `stat_stall`, output, 16: present only with `MEDIAN_ARB_STATS_EN`.

## Operation
- **Credit:**
  - `inflight` counts tagged beats inside the pipe and ranges 0..`PIPE_LAT`+1.
  - `count` is the FIFO occupancy.
  - `credit_ok` = (`inflight` + `count` < `DEPTH`). It uses the registered values, so a same-cycle pop does not add credit.
- **Grant:**
  - Round-robin pointer `last`.
  - The winner is the first requester with `req_valid` high, searching from `last`+1 upward with wrap.
  - `req_ready` = one-hot winner, and only when `credit_ok` is high. It is combinational from `req_valid`.
  - Requesters must not make `req_valid` depend on `req_ready`.
- **Accept (at edge T):**
  - `pipe_x` <= the winner's window.
  - `last` <= the winner.
  - A tag {1, id} enters a `PIPE_LAT`+1 deep shift register.
  - With no accept, a tag {0, x} enters and `pipe_x` holds its value.
- **Collect:** when the tag at the tail is valid, `pipe_median` and its id are pushed into the FIFO.
  - Credit guarantees the FIFO is never full at push time.
  - Verification asserts this.
- **Pop:** FIFO pop happens when `out_valid` and `out_ready` are both high.
  - Push and pop may occur in the same cycle, including at the full and empty boundaries. `count` is then unchanged.
- **Counter update:** `inflight` += accept − tail_valid, in the same edge.
- **Pointers:** FIFO read and write pointers are `FIDW` bits wide and wrap modulo `DEPTH`.
- **No stall path:** the pipe is never stalled. The block's only flow control is withholding `req_ready`.

## Timing
- **Reset values:**
  - `req_ready` = 0 while `rst_n` = 0.
  - `out_valid` = 0; `out_data` = 0; `out_id` = 0.
  - `pipe_x` = 0.
  - All tags invalid; `inflight` = 0; `count` = 0; `last` = `NREQ`−1, so requester 0 wins first.
- **Reset mid-operation:** all in-flight tags and FIFO contents are discarded. Medians that later emerge from the pipe are ignored because their tags are invalid.
- **Latency:**
  - Window accepted at edge T → pushed at edge T+`PIPE_LAT`+1 → `out_valid` high from that edge, i.e. T+22 at default parameters.
  - There is no FIFO bypass.
- **Throughput:** one window per cycle, sustained with `out_ready` = 1, since `DEPTH` ≥ `PIPE_LAT`+2.
- **Ordering:** results leave in acceptance order.
- **Output stability:** `out_data` and `out_id` are stable while `out_valid` is high and `out_ready` is low.

## Configuration
- **`MEDIAN_ARB_STATS_EN` defined:**
  - `stat_grants[i]` is a 16-bit saturating count of accepts from requester i.
  - `stat_stall` is a 16-bit saturating count of cycles where some `req_valid` is high and `credit_ok` is low.
  - Both counters reset to 0.
- **`MEDIAN_ARB_STATS_EN` undefined:** these ports and counters do not exist. All other behaviour is identical.

## Test plan
- **Single window:** req0 window {9,1,8,2,7,3,6,4,5} accepted at edge T, `out_ready` = 1 → `out_valid` at T+22 for one cycle with `out_data` = 5, `out_id` = 0.
- **Contention:** both requesters valid continuously for 8 cycles → grants alternate 0,1,0,1…. Results arrive in the same order with matching ids and medians, with no bubbles.
- **Backpressure:**
  - Stimulus: `out_ready` = 0, req0 always valid.
  - Exactly 32 accepts occur, then `req_ready` = 0. `count` reaches 32 and no result is lost.
  - Raising `out_ready` for 1 cycle re-enables exactly one accept on the following cycle.
- **Reset mid-flight:** `rst_n` pulsed low for 1 cycle with 10 windows in flight → `out_valid` never rises for those windows. A new window after reset yields its result at +22 cycles.
- **Full-boundary pop/push:** FIFO full with `out_ready` = 1 and requests pending → a push and a pop occur in the same cycle, `count` holds, and the FIFO never overflows.
- **Stats (macro defined):** 70000 cycles of continuous req0 with `out_ready` = 1 → `stat_grants[0]` saturates at 65535 and `stat_stall` = 0.
